// File: rtl/conv_tile_ctrl.sv
// conv_tile_ctrl: sequences one convolution tile on the 16-PE cluster.
// Drives the IFM/weight BRAM read addresses, per-PE accumulate/finish
// flags (one cycle behind the issue to cover BRAM latency) and the OFM
// valid/ready handshake toward the writer.
// Optional build macro CONV_TILE_CTRL_PERF_EN adds a saturating
// perf_cycles counter of busy cycles, cleared when a tile is accepted.
module conv_tile_ctrl #(
    parameter int unsigned NUM_PE     = 16,
    parameter int unsigned W_ADDR_W   = 20,
    parameter int unsigned IFM_ADDR_W = 7,
    parameter int unsigned STEP_W     = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [STEP_W-1:0]            num_steps,
    input  logic [IFM_ADDR_W-1:0]        ifm_base,
    input  logic [W_ADDR_W-1:0]          w_base,
    input  logic [W_ADDR_W-1:0]          w_stride,
    input  logic [NUM_PE-1:0]            pe_mask,
    input  logic                         ofm_ready,
`ifdef CONV_TILE_CTRL_PERF_EN
    output logic [31:0]                  perf_cycles,
`endif
    output logic [IFM_ADDR_W-1:0]        ifm_addr,
    output logic [NUM_PE*W_ADDR_W-1:0]   w_addr,
    output logic [NUM_PE-1:0]            pe_en,
    output logic [NUM_PE-1:0]            pe_finish,
    output logic                         ofm_valid,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned WA_W = NUM_PE * W_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [STEP_W-1:0]       cnt_q, cnt_d;
    logic [STEP_W-1:0]       steps_q, steps_d;
    logic [NUM_PE-1:0]       mask_q, mask_d;
    logic [IFM_ADDR_W-1:0]   ifm_addr_d;
    logic [WA_W-1:0]         w_addr_d;
    logic [WA_W-1:0]         w_init;
    logic [NUM_PE-1:0]       pe_en_d, pe_finish_d;
    logic                    ofm_valid_d, busy_d, done_d;

    // Per-PE starting weight address: w_base + i*w_stride, modulo 2^W_ADDR_W
    for (genvar g = 0; g < NUM_PE; g++) begin : g_w_init
        assign w_init[g*W_ADDR_W +: W_ADDR_W] = w_base + W_ADDR_W'(g) * w_stride;
    end

    // State register and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            steps_q   <= '0;
            mask_q    <= '0;
            ifm_addr  <= '0;
            w_addr    <= '0;
            pe_en     <= '0;
            pe_finish <= '0;
            ofm_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            steps_q   <= steps_d;
            mask_q    <= mask_d;
            ifm_addr  <= ifm_addr_d;
            w_addr    <= w_addr_d;
            pe_en     <= pe_en_d;
            pe_finish <= pe_finish_d;
            ofm_valid <= ofm_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    // Next-state and next-output logic; abort overrides any advance
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        steps_d     = steps_q;
        mask_d      = mask_q;
        ifm_addr_d  = ifm_addr;
        w_addr_d    = w_addr;
        pe_en_d     = '0;
        pe_finish_d = '0;
        ofm_valid_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    steps_d = num_steps;
                    mask_d  = pe_mask;
                    if (num_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = RUN;
                        cnt_d      = '0;
                        ifm_addr_d = ifm_base;
                        w_addr_d   = w_init;
                    end
                end
            end
            RUN: begin
                pe_en_d    = mask_q;
                ifm_addr_d = ifm_addr + IFM_ADDR_W'(1);
                for (int i = 0; i < int'(NUM_PE); i++) begin
                    w_addr_d[i*W_ADDR_W +: W_ADDR_W] =
                        w_addr[i*W_ADDR_W +: W_ADDR_W] + W_ADDR_W'(1);
                end
                cnt_d = cnt_q + STEP_W'(1);
                if (cnt_q == steps_q - STEP_W'(1)) begin
                    pe_finish_d = mask_q;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                state_d     = OUT;
                ofm_valid_d = 1'b1;
            end
            OUT: begin
                if (ofm_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ofm_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            ifm_addr_d  = '0;
            w_addr_d    = '0;
            pe_en_d     = '0;
            pe_finish_d = '0;
            ofm_valid_d = 1'b0;
            done_d      = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

`ifdef CONV_TILE_CTRL_PERF_EN
    logic start_acc_c;
    assign start_acc_c = (state_q == IDLE) && start;

    // Busy-cycle counter: cleared on tile accept, saturates, holds after done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles <= '0;
        end else if (start_acc_c) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_tile_ctrl.sv
// Self-checking bench for conv_tile_ctrl: per-cycle expected outputs are
// derived from the tile timing rules, queued when a tile is launched and
// popped/compared each cycle while the tile runs.
module tb_conv_tile_ctrl;

    localparam int unsigned NUM_PE = 16;
    localparam int unsigned W      = 20;
    localparam int unsigned IW     = 7;
    localparam int unsigned SW     = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start, abort, ofm_ready;
    logic [SW-1:0]          num_steps;
    logic [IW-1:0]          ifm_base;
    logic [W-1:0]           w_base, w_stride;
    logic [NUM_PE-1:0]      pe_mask;
    logic [IW-1:0]          ifm_addr;
    logic [NUM_PE*W-1:0]    w_addr;
    logic [NUM_PE-1:0]      pe_en, pe_finish;
    logic                   ofm_valid, busy, done;
`ifdef CONV_TILE_CTRL_PERF_EN
    logic [31:0]            perf_cycles;
`endif

    conv_tile_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .num_steps (num_steps),
        .ifm_base  (ifm_base),
        .w_base    (w_base),
        .w_stride  (w_stride),
        .pe_mask   (pe_mask),
        .ofm_ready (ofm_ready),
`ifdef CONV_TILE_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .ifm_addr  (ifm_addr),
        .w_addr    (w_addr),
        .pe_en     (pe_en),
        .pe_finish (pe_finish),
        .ofm_valid (ofm_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0]     ifm;
        logic [W-1:0]      w0, w3, w15;
        logic [NUM_PE-1:0] en, fin;
        logic              valid, busy, done;
        logic [31:0]       perf;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [IW-1:0] prev_ifm;
    logic [W-1:0]  prev_w [NUM_PE];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [W-1:0] w_slice(input int i);
        return w_addr[i*W +: W];
    endfunction

    function automatic logic [W-1:0] exp_w(input int i, input logic [W-1:0] wb,
                                           input logic [W-1:0] ws, input int k);
        return W'(32'(wb) + 32'(i) * 32'(ws) + 32'(k));
    endfunction

    // Expected trace for cycles 1..len after the start edge
    task automatic push_trace(input int n, input logic [IW-1:0] ib, input logic [W-1:0] wb,
                              input logic [W-1:0] ws, input logic [NUM_PE-1:0] m,
                              input int s, input int ac, input int len);
        for (int c = 1; c <= len; c++) begin
            exp_t r;
            int   k;
            bit   live;
            live = (ac == 0) || (c <= ac);
            if (n == 0) begin
                r.ifm = prev_ifm; r.w0 = prev_w[0]; r.w3 = prev_w[3]; r.w15 = prev_w[15];
                r.en = '0; r.fin = '0; r.valid = 1'b0; r.busy = 1'b0;
                r.done = (c == 1); r.perf = 32'd0;
            end else if (!live) begin
                r.ifm = '0; r.w0 = '0; r.w3 = '0; r.w15 = '0;
                r.en = '0; r.fin = '0; r.valid = 1'b0; r.busy = 1'b0;
                r.done = 1'b0; r.perf = 32'(ac);
            end else begin
                k      = (c - 1 < n) ? c - 1 : n;
                r.ifm  = IW'(32'(ib) + 32'(k));
                r.w0   = exp_w(0, wb, ws, k);
                r.w3   = exp_w(3, wb, ws, k);
                r.w15  = exp_w(15, wb, ws, k);
                r.en   = (c >= 2 && c <= n + 1) ? m : '0;
                r.fin  = (c == n + 1) ? m : '0;
                r.valid = (c >= n + 2) && (c <= n + 2 + s);
                r.busy  = (c <= n + 2 + s);
                r.done  = (c == n + 3 + s);
                r.perf  = 32'((c - 1 < n + 2 + s) ? c - 1 : n + 2 + s);
            end
            sb.push_back(r);
        end
        if (n != 0) begin
            for (int i = 0; i < int'(NUM_PE); i++)
                prev_w[i] = (ac != 0) ? '0 : exp_w(i, wb, ws, n);
            prev_ifm = (ac != 0) ? '0 : IW'(32'(ib) + 32'(n));
        end
    endtask

    // Launch a tile, then compare each cycle against the queued trace
    task automatic run_tile(input string name, input int n, input logic [IW-1:0] ib,
                            input logic [W-1:0] wb, input logic [W-1:0] ws,
                            input logic [NUM_PE-1:0] m, input int s, input int ac,
                            input bit abort_at_start, input int pulse_c, input int len);
        push_trace(n, ib, wb, ws, m, s, ac, len);
        start = 1'b1; num_steps = SW'(n); ifm_base = ib; w_base = wb; w_stride = ws;
        pe_mask = m; abort = abort_at_start; ofm_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        for (int c = 1; c <= len; c++) begin
            exp_t r;
            r = sb.pop_front();
            check($sformatf("%s c%0d ifm_addr", name, c), 32'(ifm_addr), 32'(r.ifm));
            check($sformatf("%s c%0d w_addr0", name, c), 32'(w_slice(0)), 32'(r.w0));
            check($sformatf("%s c%0d w_addr3", name, c), 32'(w_slice(3)), 32'(r.w3));
            check($sformatf("%s c%0d w_addr15", name, c), 32'(w_slice(15)), 32'(r.w15));
            check($sformatf("%s c%0d pe_en", name, c), 32'(pe_en), 32'(r.en));
            check($sformatf("%s c%0d pe_finish", name, c), 32'(pe_finish), 32'(r.fin));
            check($sformatf("%s c%0d ofm_valid", name, c), 32'(ofm_valid), 32'(r.valid));
            check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(r.busy));
            check($sformatf("%s c%0d done", name, c), 32'(done), 32'(r.done));
`ifdef CONV_TILE_CTRL_PERF_EN
            check($sformatf("%s c%0d perf", name, c), perf_cycles, r.perf);
`endif
            ofm_ready = !((c >= n + 2) && (c <= n + 1 + s));
            abort     = (c == ac);
            if (c == pulse_c) begin
                start = 1'b1; num_steps = 16'd2; ifm_base = 7'd99;
                w_base = 20'h12345; pe_mask = 16'h00F0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0; ofm_ready = 1'b1;
    endtask

    task automatic check_idle_zero(input string name);
        check({name, " ifm_addr"}, 32'(ifm_addr), 32'd0);
        check({name, " w_addr0"}, 32'(w_slice(0)), 32'd0);
        check({name, " w_addr15"}, 32'(w_slice(15)), 32'd0);
        check({name, " pe_en"}, 32'(pe_en), 32'd0);
        check({name, " pe_finish"}, 32'(pe_finish), 32'd0);
        check({name, " ofm_valid"}, 32'(ofm_valid), 32'd0);
        check({name, " busy"}, 32'(busy), 32'd0);
        check({name, " done"}, 32'(done), 32'd0);
`ifdef CONV_TILE_CTRL_PERF_EN
        check({name, " perf"}, perf_cycles, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; ofm_ready = 1'b1;
        num_steps = '0; ifm_base = '0; w_base = '0; w_stride = '0; pe_mask = '0;
        prev_ifm = '0;
        for (int i = 0; i < int'(NUM_PE); i++) prev_w[i] = '0;
        #12;
        check_idle_zero("reset");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        run_tile("basic", 4, 7'd5, 20'h00100, 20'h00040, 16'hFFFF, 0, 0, 1'b0, 0, 8);
        run_tile("bp", 4, 7'd5, 20'h00100, 20'h00040, 16'hFFFF, 3, 0, 1'b0, 7, 11);
        run_tile("wrap", 3, 7'd126, 20'hFFFFE, 20'h00000, 16'h0005, 0, 0, 1'b1, 0, 7);
        run_tile("zero", 0, 7'd40, 20'h00ABC, 20'h00010, 16'hFFFF, 0, 0, 1'b0, 0, 2);
        run_tile("abort", 8, 7'd20, 20'h00200, 20'h00100, 16'h00FF, 0, 3, 1'b0, 0, 4);
        run_tile("perf", 4, 7'd64, 20'h01000, 20'h00008, 16'hA5A5, 2, 0, 1'b0, 0, 10);
        run_tile("mask0", 2, 7'd10, 20'h00300, 20'h00020, 16'h0000, 0, 0, 1'b0, 0, 6);
        run_tile("n1", 1, 7'd127, 20'hFFFF0, 20'h00001, 16'h8001, 1, 0, 1'b0, 0, 6);

        // Asynchronous reset in the middle of a run
        run_tile("pre_rst", 8, 7'd30, 20'h00400, 20'h00010, 16'hFFFF, 0, 0, 1'b0, 0, 2);
        reset = 1'b0;
        #1;
        check_idle_zero("mid_rst");
        prev_ifm = '0;
        for (int i = 0; i < int'(NUM_PE); i++) prev_w[i] = '0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst busy", 32'(busy), 32'd0);
        check("post_rst done", 32'(done), 32'd0);
        run_tile("recover", 2, 7'd3, 20'h00050, 20'h00004, 16'h0F0F, 0, 0, 1'b0, 0, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_tile_ctrl.md
Name: conv_tile_ctrl

Overview:
- Sequencer for one convolution tile on the 16-PE cluster datapath (IFM BRAM, 16 weight BRAMs, PE_cluster).
- Generates the IFM read address, 16 per-PE weight read addresses, PE_en and PE_finish for an N-step accumulation.
- Presents OFM-valid to the downstream writer and handshakes with it.
- Sits between the layer-level scheduler (start/done) and the conv datapath.

Parameters:
- NUM_PE, 16, number of PEs / weight BRAMs driven
- W_ADDR_W, 20, weight BRAM address width
- IFM_ADDR_W, 7, IFM BRAM address width
- STEP_W, 16, width of the accumulation step count

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin tile; sampled only in IDLE
- abort  in  1  synchronous cancel; return to IDLE next cycle, no done
- num_steps  in  STEP_W  accumulation length N (32-bit words), latched at start
- ifm_base  in  IFM_ADDR_W  first IFM address, latched at start
- w_base  in  W_ADDR_W  weight address of PE0, latched at start
- w_stride  in  W_ADDR_W  per-PE weight offset, latched at start
- pe_mask  in  NUM_PE  PEs enabled this tile, latched at start
- ofm_ready  in  1  downstream accepts OFM
- ifm_addr  out  IFM_ADDR_W  IFM BRAM read address
- w_addr  out  NUM_PE*W_ADDR_W  packed weight addresses; slice i = PE i
- pe_en  out  NUM_PE  PE accumulate enable
- pe_finish  out  NUM_PE  PE last-step flag
- ofm_valid  out  1  OFM_0..15 valid, held until ofm_ready
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse, tile complete

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latched config 0.
- Read latency: BRAM is 1 cycle, so pe_en/pe_finish are the issue/last flags delayed by one register.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE -> RUN on start with N != 0:
  - latch config;
  - ifm_addr = ifm_base;
  - w_addr[i] = w_base + i*w_stride, truncated to W_ADDR_W;
  - step counter = 0.
- IDLE with start and N == 0: no PE activity; done pulses next cycle; stay IDLE.
- RUN: every cycle, issue the current addresses, then ifm_addr += 1, every w_addr[i] += 1, counter += 1. When counter == N-1 (last issue), go to DRAIN.
- Addresses wrap modulo 2^IFM_ADDR_W / 2^W_ADDR_W; no error is raised.
- DRAIN: one cycle; addresses hold their last issued value +1 (don't-care to BRAM).
- pe_en = pe_mask in the cycle after each issue, else 0.
- pe_finish = pe_mask in the cycle after the last issue only (coincides with the last pe_en).
- DRAIN -> OUT: ofm_valid = 1, held until ofm_ready = 1.
- On the OUT handshake: ofm_valid = 0, done = 1 for one cycle, -> IDLE.
- Timing, start sampled at edge 0:
  - addresses issued cycles 1..N;
  - pe_en cycles 2..N+1;
  - pe_finish cycle N+1;
  - ofm_valid from cycle N+2;
  - done the cycle after the handshake.
- busy = 1 in RUN, DRAIN and OUT; 0 in the done cycle.
- start while busy: ignored; config is not re-latched.
- abort in any non-IDLE state:
  - next cycle IDLE;
  - pe_en, pe_finish, ofm_valid, busy = 0;
  - no done.
- abort has priority over ofm_ready and over state advance. abort in IDLE: no effect.
- Asynchronous reset mid-tile: immediate return to the reset values; no done.
- pe_mask == 0: full sequence and done still occur; pe_en and pe_finish stay 0.
- Combined start+abort in IDLE: abort ignored, start honoured.

Optional Feature:
- Macro: CONV_TILE_CTRL_PERF_EN.
- Defined:
  - adds output perf_cycles [31:0], reset 0;
  - increments every cycle busy = 1, saturating at 2^32-1;
  - cleared when start is accepted;
  - holds its value after done.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic tile: ifm_base=5, w_base=0x100, w_stride=0x40, N=4, mask=0xFFFF, ofm_ready=1 -> ifm_addr 5,6,7,8 in cycles 1-4; w_addr[3] 0x1C0..0x1C3; pe_en=0xFFFF cycles 2-5; pe_finish=0xFFFF cycle 5 only; ofm_valid cycle 6; done cycle 7.
- Backpressure: same tile, ofm_ready=0 for 3 cycles after ofm_valid rises -> ofm_valid held 4 cycles, busy=1 throughout, done one cycle after ready; start pulsed meanwhile is ignored.
- Wrap and mask: ifm_base=126, w_base=0xFFFFE, w_stride=0, N=3, mask=0x0005 -> ifm_addr 126,127,0; w_addr[0] 0xFFFFE,0xFFFFF,0x00000; pe_en=0x0005 only.
- Zero length: N=0 with start -> no pe_en, no ofm_valid, busy=0, done pulse in cycle 1.
- Abort/reset: abort asserted in cycle 3 of an N=8 tile -> all outputs 0 from cycle 4, no done, new start accepted next cycle. Reset deasserted-low mid-RUN -> outputs 0 immediately.
- Perf (macro defined): N=4 tile with 2 stall cycles -> perf_cycles = 8 after done; cleared on the next start.
